// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: phase encoding and default sizes.
package alu_op_sequencer_pkg;

    localparam int SEQ_WIDTH_DEF       = 16;
    localparam int SEQ_OP_W_DEF        = 3;
    localparam int SEQ_STEP_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DRIVE  = 3'd4,
        ST_RESP   = 3'd5
    } seq_state_e;

    // Phases that hold one toplevel_ALU enable for a fixed number of clocks.
    function automatic logic is_timed_phase(input seq_state_e st);
        return (st == ST_LOAD_A) || (st == ST_LOAD_B) || (st == ST_EXEC) || (st == ST_DRIVE);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_step_timer.sv
// Phase duration counter: counts 0..STEP_CYCLES-1 and flags the final cycle of a phase.
module alu_op_sequencer_step_timer #(
    parameter int STEP_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic last
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             last_r;

    // Next count: restart on a phase change, otherwise saturate at the final step.
    always_comb begin
        count_s = count_r;
        if (clear) begin
            count_s = {CNT_W{1'b0}};
        end else if (count_r != CNT_LAST) begin
            count_s = count_r + CNT_W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Counter and registered last-step flag, so the flag is valid in the same cycle as the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            last_r  <= (CNT_LAST == {CNT_W{1'b0}});
        end else begin
            count_r <= count_s;
            last_r  <= (count_s == CNT_LAST);
        end
    end

    assign last = last_r;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command through toplevel_ALU: load R0, load R1, execute into R2, read R2 back.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH       = SEQ_WIDTH_DEF,
    parameter int OP_W        = SEQ_OP_W_DEF,
    parameter int STEP_CYCLES = SEQ_STEP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             r0en,
    output logic             r1en,
    output logic             r2en,
    output logic [OP_W-1:0]  ALU_Sel,
    output logic             aluOutEn,
    inout  wire  [WIDTH-1:0] bus
);

    seq_state_e       state_r;
    seq_state_e       state_s;
    logic             accept_s;
    logic             phase_done_s;
    logic             step_last_s;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] drive_data_r;
    logic [WIDTH-1:0] drive_data_s;
    logic             drive_en_r;
    logic [OP_W-1:0]  alu_sel_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             cmd_ready_r;
    logic             rsp_valid_r;
    logic             r0en_r;
    logic             r1en_r;
    logic             r2en_r;
    logic             alu_out_en_r;

    alu_op_sequencer_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_s != state_r),
        .last  (step_last_s)
    );

    assign phase_done_s = is_timed_phase(state_r) && step_last_s;

    // Next-state decode and command acceptance.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_LOAD_A;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_LOAD_A: if (phase_done_s) state_s = ST_LOAD_B; else state_s = ST_LOAD_A;
            ST_LOAD_B: if (phase_done_s) state_s = ST_EXEC;   else state_s = ST_LOAD_B;
            ST_EXEC:   if (phase_done_s) state_s = ST_DRIVE;  else state_s = ST_EXEC;
            ST_DRIVE:  if (phase_done_s) state_s = ST_RESP;   else state_s = ST_DRIVE;
            ST_RESP:   if (rsp_ready)    state_s = ST_IDLE;   else state_s = ST_RESP;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Operand A goes straight from the command port so it is on the bus in the first LOAD_A cycle.
    always_comb begin
        drive_data_s = drive_data_r;
        if (accept_s) begin
            drive_data_s = cmd_a;
        end else if (state_s == ST_LOAD_B) begin
            drive_data_s = b_r;
        end else begin
            drive_data_s = drive_data_r;
        end
    end

    // State, operand latches and outputs registered from the next-state decode, so enables are one-hot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            b_r          <= {WIDTH{1'b0}};
            drive_data_r <= {WIDTH{1'b0}};
            drive_en_r   <= 1'b0;
            alu_sel_r    <= {OP_W{1'b0}};
            rsp_data_r   <= {WIDTH{1'b0}};
            cmd_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            r0en_r       <= 1'b0;
            r1en_r       <= 1'b0;
            r2en_r       <= 1'b0;
            alu_out_en_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            drive_data_r <= drive_data_s;
            if (accept_s) begin
                b_r       <= cmd_b;
                alu_sel_r <= cmd_op;
            end
            if ((state_r == ST_DRIVE) && step_last_s) begin
                rsp_data_r <= bus;
            end
            drive_en_r   <= (state_s == ST_LOAD_A) || (state_s == ST_LOAD_B);
            cmd_ready_r  <= (state_s == ST_IDLE);
            rsp_valid_r  <= (state_s == ST_RESP);
            r0en_r       <= (state_s == ST_LOAD_A);
            r1en_r       <= (state_s == ST_LOAD_B);
            r2en_r       <= (state_s == ST_EXEC);
            alu_out_en_r <= (state_s == ST_DRIVE);
        end
    end

    assign bus       = drive_en_r ? drive_data_r : {WIDTH{1'bz}};
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign r0en      = r0en_r;
    assign r1en      = r1en_r;
    assign r2en      = r2en_r;
    assign ALU_Sel   = alu_sel_r;
    assign aluOutEn  = alu_out_en_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (STEP_CYCLES=2 and 1), each paired with a small toplevel_ALU model.
module tb_alu_op_sequencer;

    localparam int W  = 16;
    localparam int OW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, sel, cmd_valid, rsp_ready, probe_on;
    logic [OW-1:0] cmd_op;
    logic [W-1:0]  cmd_a, cmd_b;

    logic          cmd_ready0, rsp_valid0, r0en0, r1en0, r2en0, aoe0;
    logic          cmd_ready1, rsp_valid1, r0en1, r1en1, r2en1, aoe1;
    logic [OW-1:0] alu_sel0, alu_sel1;
    logic [W-1:0]  rsp_data0, rsp_data1;
    wire  [W-1:0]  bus0, bus1;
    logic [W-1:0]  r0_m0, r1_m0, r2_m0, r0_m1, r1_m1, r2_m1;

    int n_checks = 0;
    int n_fail   = 0;

    // ALU semantics of toplevel_ALU as used here (000=ADD, 001=SUB, others arbitrary but fixed)
    function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    alu_op_sequencer #(.WIDTH(W), .OP_W(OW), .STEP_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data0), .r0en(r0en0), .r1en(r1en0), .r2en(r2en0), .ALU_Sel(alu_sel0),
        .aluOutEn(aoe0), .bus(bus0));

    alu_op_sequencer #(.WIDTH(W), .OP_W(OW), .STEP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data1), .r0en(r0en1), .r1en(r1en1), .r2en(r2en1), .ALU_Sel(alu_sel1),
        .aluOutEn(aoe1), .bus(bus1));

    // toplevel_ALU register models
    always_ff @(posedge clk) begin
        if (r0en0) r0_m0 <= bus0;
        if (r1en0) r1_m0 <= bus0;
        if (r2en0) r2_m0 <= alu_f(alu_sel0, r0_m0, r1_m0);
        if (r0en1) r0_m1 <= bus1;
        if (r1en1) r1_m1 <= bus1;
        if (r2en1) r2_m1 <= alu_f(alu_sel1, r0_m1, r1_m1);
    end
    assign bus0 = aoe0 ? r2_m0 : 'z;
    assign bus1 = aoe1 ? r2_m1 : 'z;
    // probe driver: only enabled while both sequencers should have released their bus
    assign bus0 = probe_on ? 16'h0000 : 'z;
    assign bus1 = probe_on ? 16'h0000 : 'z;

    logic          v_ready, v_valid, v_r0en, v_r1en, v_r2en, v_aoe;
    logic [OW-1:0] v_sel;
    logic [W-1:0]  v_data, v_bus;
    assign v_ready = sel ? cmd_ready1 : cmd_ready0;
    assign v_valid = sel ? rsp_valid1 : rsp_valid0;
    assign v_r0en  = sel ? r0en1 : r0en0;
    assign v_r1en  = sel ? r1en1 : r1en0;
    assign v_r2en  = sel ? r2en1 : r2en0;
    assign v_aoe   = sel ? aoe1 : aoe0;
    assign v_sel   = sel ? alu_sel1 : alu_sel0;
    assign v_data  = sel ? rsp_data1 : rsp_data0;
    assign v_bus   = sel ? bus1 : bus0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // at most one ALU enable per cycle on each instance
    always @(negedge clk) begin
        if (!rst) begin
            check("onehot0", 32'($countones({r0en0, r1en0, r2en0, aoe0}) <= 1), 32'd1);
            check("onehot1", 32'($countones({r0en1, r1en1, r2en1, aoe1}) <= 1), 32'd1);
        end
    end

    // One full transaction on the selected instance, with response stall and optional intruding command.
    task automatic run_cmd(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall, input bit intrude, output logic [W-1:0] data);
        int s, cyc, k;
        int codes[$];
        bit order_err;
        logic [W-1:0] held;
        s = sel ? 1 : 2;
        k = 0;
        while (!v_ready && k < 50) begin @(negedge clk); k++; end
        check("ready_wait", 32'(v_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = (stall == 0);
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 1) cmd_valid = 1'b0;
            if (intrude && cyc == 3) begin
                cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
                check("busy_ready_a", 32'(v_ready), 32'd0);
            end
            if (intrude && cyc == 4) begin
                check("busy_ready_b", 32'(v_ready), 32'd0);
                cmd_valid = 1'b0;
            end
            if (v_r0en) codes.push_back(1);
            else if (v_r1en) codes.push_back(2);
            else if (v_r2en) codes.push_back(3);
            else if (v_aoe) codes.push_back(4);
        end while (!v_valid && cyc < 100);
        check("latency", 32'(cyc), 32'(4 * s + 1));
        check("alu_sel", 32'(v_sel), 32'(op));
        check("en_cycles", 32'(codes.size()), 32'(4 * s));
        order_err = 1'b0;
        for (int i = 0; i < codes.size(); i++) begin
            if (codes[i] != (i / s) + 1) order_err = 1'b1;
        end
        check("en_order", 32'(order_err), 32'd0);
        held = v_data;
        if (stall > 0) begin
            probe_on = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", 32'(v_valid), 32'd1);
                check("stall_data", 32'(v_data), 32'(held));
                check("stall_bus", 32'(v_bus), 32'h0000);
            end
            probe_on  = 1'b0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_done", 32'(v_valid), 32'd0);
        rsp_ready = 1'b0;
        data = held;
    endtask

    typedef struct {
        logic [OW-1:0] op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int            stall;
        bit            intrude;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t        vecs[6];
    logic [W-1:0] res;
    bit          flag;
    logic [OW-1:0] rop;
    logic [W-1:0]  ra, rb;

    initial begin
        vecs[0] = '{3'd0, 16'h0003, 16'h0004, 0, 1'b0, 16'h0007};
        vecs[1] = '{3'd1, 16'h0000, 16'h0001, 5, 1'b0, 16'hFFFF};
        vecs[2] = '{3'd0, 16'h1234, 16'h0101, 0, 1'b1, 16'h1335};
        vecs[3] = '{3'd4, 16'h00FF, 16'h0F0F, 2, 1'b0, 16'h0FF0};
        vecs[4] = '{3'd2, 16'hF0F0, 16'h3C3C, 1, 1'b0, 16'h3030};
        vecs[5] = '{3'd1, 16'h0005, 16'h0003, 0, 1'b0, 16'h0002};

        rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; probe_on = 1'b1;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(cmd_ready0), 32'd1);
        check("rst_ready1", 32'(cmd_ready1), 32'd1);
        check("rst_en0", 32'({r0en0, r1en0, r2en0, aoe0, rsp_valid0}), 32'd0);
        check("rst_en1", 32'({r0en1, r1en1, r2en1, aoe1, rsp_valid1}), 32'd0);
        check("rst_data", 32'(rsp_data0), 32'd0);
        check("rst_sel", 32'(alu_sel0), 32'd0);
        check("rst_bus0", 32'(bus0), 32'h0000);
        check("rst_bus1", 32'(bus1), 32'h0000);
        rst = 1'b0; probe_on = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].intrude, res);
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
            if (vecs[i].intrude) begin
                flag = 1'b0;
                repeat (12) begin @(negedge clk); if (rsp_valid0) flag = 1'b1; end
                check("no_second_rsp", 32'(flag), 32'd0);
                check("sel_held", 32'(alu_sel0), 32'(vecs[i].op));
            end
        end

        // reset while executing drops the command
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'h0101; cmd_b = 16'h0202;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
        end
        check("in_exec", 32'(r2en0), 32'd1);
        rst = 1'b1; probe_on = 1'b1;
        @(negedge clk);
        check("exec_rst_en", 32'({r0en0, r1en0, r2en0, aoe0, rsp_valid0}), 32'd0);
        check("exec_rst_ready", 32'(cmd_ready0), 32'd1);
        check("exec_rst_bus", 32'(bus0), 32'h0000);
        rst = 1'b0; probe_on = 1'b0;
        flag = 1'b0;
        repeat (12) begin @(negedge clk); if (rsp_valid0 || r0en0) flag = 1'b1; end
        check("dropped_cmd", 32'(flag), 32'd0);
        run_cmd(3'd0, 16'h0100, 16'h0023, 0, 1'b0, res);
        check("after_rst_result", 32'(res), 32'h0123);

        // reset wins over a simultaneous command
        rst = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready0), 32'd1);
        @(negedge clk);
        check("rst_cmd_r0en", 32'(r0en0), 32'd0);

        // STEP_CYCLES=1 instance, back to back
        sel = 1'b1;
        run_cmd(3'd0, 16'h0010, 16'h0020, 0, 1'b0, res);
        check("s1_first", 32'(res), 32'h0030);
        run_cmd(3'd0, 16'h00FF, 16'h0001, 0, 1'b0, res);
        check("s1_second", 32'(res), 32'h0100);

        // randomized commands against the ALU reference
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            rop = OW'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            run_cmd(rop, ra, rb, int'($urandom_range(0, 3)), 1'b0, res);
            check("rand_result", 32'(res), 32'(alu_f(rop, ra, rb)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
